// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the matrix-multiply result path.
//   - default element / matrix size constants
//   - idx_w(): width of a row or column index for an N x N matrix
//   - stream_state_t: unloader FSM state encoding
//   - elem_t: one signed result element at the default width
// -----------------------------------------------------------------------------
package mat_pkg;

   localparam int DEF_W_IN  = 16;
   localparam int DEF_W_OUT = 32;
   localparam int DEF_N     = 2;

   // A 1x1 matrix still needs a 1-bit index so ports never collapse to zero width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   typedef logic signed [DEF_W_OUT-1:0] elem_t;

endpackage

// File: rtl/mat_stream_out_idx.sv
// -----------------------------------------------------------------------------
// mat_idx_counter
// Row-major (row, col) position counter for an N x N matrix.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (indices -> 0)
//   i_clear      : restart at (0,0); wins over i_advance
//   i_advance    : step to the next element in row-major order
//   o_row, o_col : current position
//   o_wrap       : current position is the last element (N-1, N-1)
// -----------------------------------------------------------------------------
module mat_idx_counter
   import mat_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = idx_w(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_advance,
   output logic [IDX_W-1:0] o_row,
   output logic [IDX_W-1:0] o_col,
   output logic             o_wrap
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         if (r_col == LAST) begin
            r_col <= '0;
            // Wrapping the row back to 0 leaves the indices at (0,0) when idle.
            r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_wrap = (r_row == LAST) && (r_col == LAST);

endmodule

// File: rtl/mat_stream_out.sv
// -----------------------------------------------------------------------------
// mat_stream_out
// Captures a full N x N signed result matrix on a valid_in pulse and unloads it
// element by element, row-major, on a valid/ready stream.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and m_ready
// are both high; while m_valid is high and m_ready is low, m_data, m_row,
// m_col and m_last hold their values; m_valid never drops without a transfer
// (except on reset).
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   valid_in    : single-cycle pulse, result holds a new matrix
//   result      : packed matrix, element (i,j) at (i*N+j)*W_OUT +: W_OUT
//   in_ready    : a capture can happen this cycle (combinational)
//   m_data      : current element
//   m_valid     : stream valid
//   m_ready     : downstream accept
//   m_row/m_col : position of m_data
//   m_last      : m_data is element (N-1, N-1)
//   frame_done  : registered pulse the cycle after the last element transfers
//   overflow    : sticky, a matrix arrived while busy and was dropped
//   dbg_state   : FSM state (0 = IDLE, 1 = STREAM)
// -----------------------------------------------------------------------------
module mat_stream_out
   import mat_pkg::*;
#(
   parameter int W_OUT = DEF_W_OUT,
   parameter int N     = DEF_N,
   localparam int IDX_W = idx_w(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_in,
   input  logic [N*N*W_OUT-1:0]   result,
   output logic                   in_ready,
   output logic [W_OUT-1:0]       m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [IDX_W-1:0]       m_row,
   output logic [IDX_W-1:0]       m_col,
   output logic                   m_last,
   output logic                   frame_done,
   output logic                   overflow,
   output logic                   dbg_state
);

   stream_state_t          r_state;
   stream_state_t          w_next_state;
   logic [N*N*W_OUT-1:0]   r_buf;
   logic                   r_frame_done;
   logic                   r_overflow;

   logic                   w_hs;
   logic                   w_last_hs;
   logic                   w_in_ready;
   logic                   w_capture;
   logic                   w_drop;
   logic [IDX_W-1:0]       w_row;
   logic [IDX_W-1:0]       w_col;
   logic                   w_wrap;
   logic [W_OUT-1:0]       w_data;

   assign w_hs       = (r_state == STREAM) && m_ready;
   assign w_last_hs  = w_hs && w_wrap;
   // The slot frees up in the same cycle the last element leaves, so a new
   // matrix can follow back-to-back without an idle beat.
   assign w_in_ready = (r_state == IDLE) || w_last_hs;
   assign w_capture  = valid_in && w_in_ready;
   assign w_drop     = valid_in && !w_in_ready;

   mat_idx_counter #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_idx (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_capture),
      .i_advance (w_hs),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_wrap    (w_wrap)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state: a capture always (re)starts a frame, otherwise the last
   // transfer empties the buffer.
   always_comb begin
      w_next_state = r_state;
      if (w_capture) begin
         w_next_state = STREAM;
      end else if (w_last_hs) begin
         w_next_state = IDLE;
      end
   end

   // Capture buffer and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf        <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_capture) begin
            r_buf <= result;
         end
         r_frame_done <= w_last_hs;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Element select from the registered buffer and registered indices.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if ((w_row == IDX_W'(i)) && (w_col == IDX_W'(j))) begin
               w_data = r_buf[(i*N + j)*W_OUT +: W_OUT];
            end
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign m_valid    = (r_state == STREAM);
   assign m_data     = w_data;
   assign m_row      = w_row;
   assign m_col      = w_col;
   assign m_last     = (r_state == STREAM) && w_wrap;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_mat_stream_out.sv
module tb_mat_stream_out;

   localparam int W  = 32;
   localparam int EW = W + 3;   // {last, row, col, data}

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // N=2 instance
   logic             valid_in, m_ready, in_ready, m_valid, m_last, frame_done, overflow, dbg_state;
   logic [4*W-1:0]   result;
   logic [W-1:0]     m_data;
   logic [0:0]       m_row, m_col;

   // N=1 instance
   logic             valid_in1, m_ready1, in_ready1, m_valid1, m_last1, frame_done1, overflow1, dbg_state1;
   logic [W-1:0]     result1;
   logic [W-1:0]     m_data1;
   logic [0:0]       m_row1, m_col1;

   mat_stream_out #(.W_OUT(W), .N(2)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .result(result),
      .in_ready(in_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_row(m_row), .m_col(m_col), .m_last(m_last), .frame_done(frame_done),
      .overflow(overflow), .dbg_state(dbg_state)
   );

   mat_stream_out #(.W_OUT(W), .N(1)) dut1 (
      .clk(clk), .reset(reset), .valid_in(valid_in1), .result(result1),
      .in_ready(in_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
      .m_row(m_row1), .m_col(m_col1), .m_last(m_last1), .frame_done(frame_done1),
      .overflow(overflow1), .dbg_state(dbg_state1)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp1_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the N=2 instance: beats, stall stability, frame_done timing.
   logic          exp_fd2 = 1'b0;
   logic          stall2  = 1'b0;
   logic [EW-1:0] held2   = '0;
   always @(negedge clk) begin : mon2
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      logic          fd_next;
      act     = {m_last, m_row, m_col, m_data};
      fd_next = 1'b0;
      check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd2});
      if (stall2 && m_valid) check("stall_hold", {29'd0, act}, {29'd0, held2});
      if (!reset && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", act, $time);
         end else begin
            exp = exp_q.pop_front();
            check("beat", {29'd0, act}, {29'd0, exp});
            fd_next = exp[EW-1];
         end
      end
      exp_fd2 = fd_next;
      stall2  = !reset && m_valid && !m_ready;
      held2   = act;
   end

   // Monitor for the N=1 instance.
   logic exp_fd1 = 1'b0;
   always @(negedge clk) begin : mon1
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      logic          fd_next;
      act     = {m_last1, m_row1, m_col1, m_data1};
      fd_next = 1'b0;
      check("frame_done_n1", {63'd0, frame_done1}, {63'd0, exp_fd1});
      if (!reset && m_valid1 && m_ready1) begin
         if (exp1_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat_n1: got 0x%0h expected no beat at %0t", act, $time);
         end else begin
            exp = exp1_q.pop_front();
            check("beat_n1", {29'd0, act}, {29'd0, exp});
            fd_next = exp[EW-1];
         end
      end
      exp_fd1 = fd_next;
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse2(input logic [4*W-1:0] m);
      valid_in = 1'b1;
      result   = m;
      tick();
      valid_in = 1'b0;
   endtask

   // Expected row-major beats of a 2x2 frame.
   task automatic push2(input logic [4*W-1:0] m);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({(k == 3), (k >= 2), (k % 2 == 1), m[k*W +: W]});
      end
   endtask

   // Packed matrices: {e11, e10, e01, e00}
   localparam logic [4*W-1:0] F1 = {32'd50, 32'd43, 32'd22, 32'd19};
   localparam logic [4*W-1:0] FA = {32'd4,  32'd3,  32'd2,  32'd1};
   localparam logic [4*W-1:0] FB = {32'd6,  32'd5,  32'd0,  32'hFFFF_FFF9};
   localparam logic [4*W-1:0] F9 = {32'd9,  32'd9,  32'd9,  32'd9};

   logic pat [7];

   initial begin
      reset     = 1'b1;
      valid_in  = 1'b0;
      m_ready   = 1'b1;
      result    = '0;
      valid_in1 = 1'b0;
      m_ready1  = 1'b1;
      result1   = '0;
      pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_m_valid",  {63'd0, m_valid},  64'd0);
      check("rst_m_row",    {63'd0, m_row},    64'd0);
      check("rst_m_col",    {63'd0, m_col},    64'd0);
      check("rst_m_last",   {63'd0, m_last},   64'd0);
      check("rst_m_data",   {32'd0, m_data},   64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_state",    {63'd0, dbg_state}, 64'd0);
      check("rst_m_valid_n1", {63'd0, m_valid1}, 64'd0);

      // 1: basic frame, m_ready always high
      push2(F1);
      pulse2(F1);
      check("t1_valid_next", {63'd0, m_valid},  64'd1);
      check("t1_state",      {63'd0, dbg_state}, 64'd1);
      check("t1_in_ready",   {63'd0, in_ready}, 64'd0);
      repeat (4) tick();
      check("t1_done_valid", {63'd0, m_valid},  64'd0);
      check("t1_done_fd",    {63'd0, frame_done}, 64'd1);
      check("t1_done_state", {63'd0, dbg_state}, 64'd0);
      tick();

      // 2: same frame with m_ready pattern 1,0,0,1,1,0,1
      push2(F1);
      pulse2(F1);
      for (int k = 0; k < 7; k++) begin
         m_ready = pat[k];
         tick();
      end
      m_ready = 1'b1;
      check("t2_done_valid", {63'd0, m_valid},    64'd0);
      check("t2_done_fd",    {63'd0, frame_done}, 64'd1);
      tick();

      // 3: frame B arrives on A's last handshake
      push2(FA);
      pulse2(FA);
      repeat (3) tick();
      check("t3_in_ready_last", {63'd0, in_ready}, 64'd1);
      push2(FB);
      pulse2(FB);
      check("t3_b_valid",   {63'd0, m_valid},  64'd1);
      check("t3_b_data",    {32'd0, m_data},   64'h0000_0000_FFFF_FFF9);
      check("t3_b_row",     {63'd0, m_row},    64'd0);
      check("t3_b_col",     {63'd0, m_col},    64'd0);
      check("t3_a_fd",      {63'd0, frame_done}, 64'd1);
      check("t3_overflow",  {63'd0, overflow}, 64'd0);
      repeat (4) tick();
      check("t3_done_valid", {63'd0, m_valid}, 64'd0);
      tick();

      // 4: matrix arriving mid-frame is dropped
      push2(FA);
      pulse2(FA);
      tick();
      check("t4_at_col1", {63'd0, m_col}, 64'd1);
      pulse2(F9);
      check("t4_overflow", {63'd0, overflow}, 64'd1);
      repeat (2) tick();
      check("t4_done_valid", {63'd0, m_valid}, 64'd0);
      repeat (4) tick();
      check("t4_still_idle", {63'd0, m_valid},  64'd0);
      check("t4_sticky",     {63'd0, overflow}, 64'd1);

      // 5: reset at element (1,0) while stalled
      push2(FA);
      pulse2(FA);
      repeat (2) tick();
      check("t5_at_row1", {63'd0, m_row}, 64'd1);
      check("t5_at_col0", {63'd0, m_col}, 64'd0);
      m_ready = 1'b0;
      reset   = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      check("t5_valid",    {63'd0, m_valid},  64'd0);
      check("t5_overflow", {63'd0, overflow}, 64'd0);
      check("t5_row",      {63'd0, m_row},    64'd0);
      check("t5_col",      {63'd0, m_col},    64'd0);
      check("t5_data",     {32'd0, m_data},   64'd0);
      check("t5_state",    {63'd0, dbg_state}, 64'd0);
      m_ready = 1'b1;
      tick();
      push2(F1);
      pulse2(F1);
      repeat (4) tick();
      check("t5_after_valid", {63'd0, m_valid},    64'd0);
      check("t5_after_fd",    {63'd0, frame_done}, 64'd1);
      tick();

      // 6: N=1 single element
      exp1_q.push_back({1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF});
      valid_in1 = 1'b1;
      result1   = 32'hFFFF_FFFF;
      tick();
      valid_in1 = 1'b0;
      check("t6_valid", {63'd0, m_valid1}, 64'd1);
      check("t6_data",  {32'd0, m_data1},  64'h0000_0000_FFFF_FFFF);
      check("t6_last",  {63'd0, m_last1},  64'd1);
      tick();
      check("t6_idle",  {63'd0, m_valid1},    64'd0);
      check("t6_fd",    {63'd0, frame_done1}, 64'd1);

      repeat (3) tick();
      check("exp_q_empty",  exp_q.size(),  64'd0);
      check("exp1_q_empty", exp1_q.size(), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
